// File: rtl/div_pkg.sv
// Shared constants for the repeated-subtraction divider.
// State encoding and default operand width.
package div_pkg;

    localparam int DIV_W = 16;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LDD  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

endpackage

// File: rtl/div_repsub_if.sv
// Operand bus and result/handshake bundle for div_repsub.
// master drives start/data_in; slave is the divider.
interface div_repsub_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
);

    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start,
        output data_in,
        input  busy,
        input  done,
        input  div_by_zero,
        input  quotient,
        input  remainder
    );

    modport slave (
        input  start,
        input  data_in,
        output busy,
        output done,
        output div_by_zero,
        output quotient,
        output remainder
    );

endinterface

// File: rtl/div_repsub_datapath.sv
// R/D/Q registers, subtractor, incrementer and comparators.
// Sequenced by strobes from the controller in div_repsub.
module div_repsub_datapath
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_r,
    input  logic             load_d,
    input  logic             sat_q,
    input  logic             sub,
    output logic             ge,
    output logic             dz,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] q_inc;

    assign diff  = r_q - d_q;
    assign q_inc = q_q + WIDTH'(1);
    assign ge    = (r_q >= d_q);
    assign dz    = (data_in == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
            d_q <= '0;
            q_q <= '0;
        end else begin
            if (load_r) begin
                r_q <= data_in;
                q_q <= '0;
            end
            if (load_d) begin
                d_q <= data_in;
            end
            // Zero divisor saturates Q; R keeps the dividend.
            if (sat_q) begin
                q_q <= '1;
            end
            if (sub) begin
                r_q <= diff;
                q_q <= q_inc;
            end
        end
    end

    assign quotient  = q_q;
    assign remainder = r_q;

endmodule

// File: rtl/div_repsub.sv
// Unsigned divider by repeated subtraction, one step per cycle.
// Dividend then divisor arrive on a shared bus in consecutive cycles.
module div_repsub
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic         clk,
    input  logic         rst,
    div_repsub_if.slave  bus
);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       load_r;
    logic       load_d;
    logic       sat_q;
    logic       sub;
    logic       ge;
    logic       dz;
    logic       dbz_q;

    always_comb begin
        state_nxt = state;
        load_r    = 1'b0;
        load_d    = 1'b0;
        sat_q     = 1'b0;
        sub       = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): begin
                if (bus.start) begin
                    load_r    = 1'b1;
                    state_nxt = S_LDD;
                end
            end
            (state == S_LDD): begin
                load_d = 1'b1;
                if (dz) begin
                    sat_q     = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_RUN;
                end
            end
            (state == S_RUN): begin
                if (ge) begin
                    sub = 1'b1;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            (state == S_DONE): begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            dbz_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load_r) begin
                dbz_q <= 1'b0;
            end else if (sat_q) begin
                dbz_q <= 1'b1;
            end
        end
    end

    div_repsub_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .data_in   (bus.data_in),
        .load_r    (load_r),
        .load_d    (load_d),
        .sat_q     (sat_q),
        .sub       (sub),
        .ge        (ge),
        .dz        (dz),
        .quotient  (bus.quotient),
        .remainder (bus.remainder)
    );

    assign bus.busy        = (state == S_LDD) || (state == S_RUN);
    assign bus.done        = (state == S_DONE);
    assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_repsub.sv
// Randomised and directed checks of div_repsub against an
// arithmetic reference (/ and %, latency from quotient).
module tb_div_repsub;

    localparam int W     = 16;
    localparam int LIMIT = 70000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    div_repsub_if #(.WIDTH(W)) bus();

    div_repsub #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        int           elat;
        int           cyc;
        int           busy_n;
        string        id;
        id   = $sformatf("%0d/%0d", a, b);
        edz  = (b == 0);
        eq   = edz ? {W{1'b1}} : a / b;
        er   = edz ? a : a % b;
        elat = edz ? 2 : 3 + int'(a / b);
        bus.start   = 1'b1;
        bus.data_in = a;
        tick();
        bus.start   = 1'b0;
        bus.data_in = b;
        cyc    = 1;
        busy_n = 0;
        while (!bus.done && cyc < LIMIT) begin
            if (bus.busy) busy_n++;
            if (poke && cyc == 3) begin
                bus.start   = 1'b1;
                bus.data_in = W'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            tick();
            cyc++;
        end
        bus.start = 1'b0;
        check({id, " latency"}, cyc, elat);
        if (bus.done) begin
            check({id, " quotient"}, 32'(bus.quotient), 32'(eq));
            check({id, " remainder"}, 32'(bus.remainder), 32'(er));
            check({id, " dbz"}, 32'(bus.div_by_zero), 32'(edz));
            check({id, " busy_at_done"}, 32'(bus.busy), 0);
            check({id, " busy_cycles"}, busy_n, elat - 1);
        end
        tick();
        check({id, " done_pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           hi;
        bus.start   = 1'b0;
        bus.data_in = '0;
        tick();
        tick();
        check("rst busy", 32'(bus.busy), 0);
        check("rst done", 32'(bus.done), 0);
        check("rst dbz", 32'(bus.div_by_zero), 0);
        check("rst q", 32'(bus.quotient), 0);
        check("rst r", 32'(bus.remainder), 0);
        rst = 1'b0;
        tick();

        run_op(16'd100, 16'd7, 1'b0);
        run_op(16'd5, 16'd9, 1'b0);
        run_op(16'd0, 16'd3, 1'b0);
        run_op(16'd20, 16'd0, 1'b0);
        run_op(16'd9, 16'd3, 1'b0);
        run_op(16'd65535, 16'd65535, 1'b0);
        run_op(16'd65535, 16'd1, 1'b0);
        run_op(16'd500, 16'd13, 1'b1);
        run_op(16'd77, 16'd8, 1'b0);

        // Abort a long division partway through RUN.
        bus.start   = 1'b1;
        bus.data_in = 16'd1000;
        tick();
        bus.start   = 1'b0;
        bus.data_in = 16'd3;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check("midrst busy", 32'(bus.busy), 0);
        check("midrst done", 32'(bus.done), 0);
        check("midrst dbz", 32'(bus.div_by_zero), 0);
        check("midrst q", 32'(bus.quotient), 0);
        check("midrst r", 32'(bus.remainder), 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst no_done", 32'(bus.done), 0);
        end
        run_op(16'd10, 16'd4, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                b = '0;
            end else begin
                b = W'($urandom_range(1, 65535));
            end
            hi = (b == 0) ? 65535 : int'(b) * 200;
            if (hi > 65535) hi = 65535;
            a = W'($urandom_range(0, hi));
            run_op(a, b, ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
